bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side master for the 256x32 weight/activation BRAM in the paramul datapath.
- On a start command it walks a contiguous address range, driving the BRAM read port (address, read enable, registered 1-cycle read data).
- Returned words are presented as a valid/ready stream to the multiplier lanes, with full backpressure and 1 word/cycle throughput.

Parameters:
- ADDR_W, 8: BRAM address width; depth is 2**ADDR_W.
- DATA_W, 32: BRAM word width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  command strobe; accepted only in IDLE
- i_base  in  ADDR_W  first address, sampled with i_start
- i_len  in  ADDR_W+1  word count, 0..256
- o_busy  out  1  high from the cycle after start acceptance until o_done
- o_done  out  1  one-cycle pulse at command completion
- o_rd_addr  out  ADDR_W  to BRAM o_addr
- o_rd_en  out  1  to BRAM read
- i_rd_data  in  DATA_W  from BRAM o_read; valid the cycle after o_rd_en
- o_data  out  DATA_W  stream payload
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready from consumer

Behaviour:
- Reset values:
  - o_busy, o_done, o_rd_en, o_valid = 0.
  - o_rd_addr, o_data = 0.
  - Internal counters and the skid FIFO are cleared.
- State machine:
  - IDLE → RUN on i_start when i_len != 0. Latch base and len; issue counter = 0.
  - IDLE → DONE on i_start when i_len == 0. No BRAM reads are issued.
  - RUN → DRAIN when the last read has been issued.
  - DRAIN → DONE when the skid FIFO is empty, nothing is in flight, and the last beat has handshaken.
  - DONE → IDLE unconditionally. o_done = 1 only in DONE.
- Read issue:
  - o_rd_en and o_rd_addr are registered.
  - Address = base + issue counter, modulo 2**ADDR_W. Wrap is legal: base=0xFE, len=4 reads FE, FF, 00, 01.
  - A read is issued only if (FIFO occupancy + reads in flight − pop this cycle) < 2. The BRAM output is never overwritten before capture.
- Skid FIFO:
  - 2 entries, DATA_W wide.
  - Push: the cycle after o_rd_en, capturing i_rd_data.
  - o_valid = FIFO non-empty; o_data = FIFO head.
  - Pop on o_valid & i_ready.
  - Simultaneous push and pop keeps occupancy constant.
- Latency and throughput:
  - i_start high in cycle 0 → o_rd_en first high in cycle 1 → o_valid first high in cycle 2.
  - With i_ready held high: one beat per cycle; the last beat is in cycle len+1; o_done is in cycle len+2.
- Backpressure:
  - While i_ready = 0, o_data and o_valid hold stable.
  - Reads stall once 2 words are buffered or in flight.
  - No word is dropped or duplicated.
- Ignored inputs:
  - i_start while not in IDLE is ignored.
  - i_base and i_len are don't-care outside the start cycle.
- Reset mid-operation: returns to IDLE immediately. Any in-flight BRAM data arriving after reset is discarded; o_valid stays 0.
- The block never drives the BRAM write port. Concurrent writes to addresses already read do not affect delivered data.

Decomposition:
- Shared package paramul_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum: IDLE, RUN, DRAIN, DONE.
- One natural sub-module: skid_fifo2, a 2-entry FIFO with push/pop, occupancy count and head output, reusable by other BRAM-fed stages.

Test Plan:
- Basic stream: BRAM preloaded mem[a] = a*3, base=0x10, len=4, i_ready=1.
  - Response: beats 0x30, 0x33, 0x36, 0x39 in cycles 2–5; o_done in cycle 6; exactly 4 o_rd_en pulses.
- Wrap-around: base=0xFE, len=4.
  - Response: o_rd_addr sequence FE, FF, 00, 01; data in the same order.
- Backpressure: len=8, i_ready toggling 1,0,0,1,... pseudo-randomly.
  - Response: all 8 words in order, no duplicates.
  - o_data stable while o_valid & !i_ready.
  - Never more than 2 reads outstanding plus buffered.
- Zero length and ignored start: len=0 → o_done in cycle 1, no o_rd_en. Second i_start during a len=16 run → ignored, exactly 16 beats.
- Full depth: base=0, len=256, i_ready=1 → 256 beats in cycles 2–257, o_done in cycle 258.
- Reset mid-run: assert rst asynchronously after 3 beats of len=10.
  - Response: all outputs 0 immediately; no o_valid after deassertion.
  - A new len=2 command afterwards completes correctly.

Source files
------------

// File: rtl/paramul_pkg.sv
// ---------------------------------------------------------------------------
// paramul_pkg : shared BRAM geometry and reader state encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package paramul_pkg;

    localparam int BRAM_ADDR_W = 8;
    localparam int BRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/skid_fifo2.sv
// ---------------------------------------------------------------------------
// skid_fifo2 : 2-entry fall-through FIFO with occupancy and head output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skid_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              bypass;
    logic              wr;
    logic              rd;

    // An incoming word popped in the same cycle it arrives into an empty
    // FIFO never gets stored; this keeps the stream at one word per cycle.
    assign bypass  = i_push & i_pop & (count_q == 2'd0);
    assign wr      = i_push & ~bypass;
    assign rd      = i_pop & (count_q != 2'd0);

    assign o_valid = (count_q != 2'd0) | i_push;
    assign o_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q]
                   : (i_push ? i_data : '0);
    assign o_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= i_data;
            end
            wr_ptr_q <= wr_ptr_q ^ wr;
            rd_ptr_q <= rd_ptr_q ^ rd;
            count_q  <= count_q + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader : walks a BRAM address range and streams the words out
// over valid/ready with full backpressure. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_stream_reader
    import paramul_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rd_en_q, rd_en_d;
    logic              vld_q;

    logic              fifo_valid;
    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occ_next;
    logic [2:0]        fill;
    logic              can_issue;

    assign pop       = fifo_valid & i_ready;
    // Words that will be buffered after this edge, plus the read the BRAM is
    // servicing now; a new read may only go out if it still fits in 2 slots.
    assign occ_next  = {1'b0, fifo_count} + {2'b0, vld_q} - {2'b0, pop};
    assign fill      = occ_next + {2'b0, rd_en_q};
    assign can_issue = (fill < 3'd2);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        state_d   = RUN;
                        base_d    = i_base;
                        len_d     = i_len;
                        rd_en_d   = 1'b1;
                        rd_addr_d = i_base;
                        cnt_d     = (ADDR_W+1)'(1);
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            RUN: begin
                if (cnt_q == len_q) begin
                    state_d = DRAIN;
                end else if (can_issue) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + cnt_q[ADDR_W-1:0];
                    cnt_d     = cnt_q + (ADDR_W+1)'(1);
                end
            end
            DRAIN: begin
                if (!rd_en_q && occ_next == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            vld_q     <= rd_en_q;
        end
    end

    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (vld_q),
        .i_data  (i_rd_data),
        .i_pop   (pop),
        .o_valid (fifo_valid),
        .o_data  (o_data),
        .o_count (fifo_count)
    );

    assign o_valid   = fifo_valid;
    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;
    assign o_busy    = (state_q == RUN) || (state_q == DRAIN);
    assign o_done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader : scoreboard bench with a BRAM model and random ready.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base = '0;
    logic [8:0]  i_len = '0;
    logic        o_busy, o_done, o_rd_en, o_valid;
    logic [7:0]  o_rd_addr;
    logic [31:0] i_rd_data = '0;
    logic [31:0] o_data;
    logic        i_ready = 1'b1;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [7:0]  addr_q [$];

    int vec = 0, errs = 0, cyc = 0, t0 = 0;
    int beats, rd_cnt, first_rel, last_rel, done_rel;
    int issued = 0, popped = 0;
    bit rnd_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    bram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_base    (i_base),
        .i_len     (i_len),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_rd_addr (o_rd_addr),
        .o_rd_en   (o_rd_en),
        .i_rd_data (i_rd_data),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    // BRAM with a registered read port
    always @(posedge clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

    initial forever begin
        @(posedge clk); #1;
        i_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec = vec + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a read or a beat
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, prev_data);
            end
            if (o_rd_en) begin
                rd_cnt = rd_cnt + 1;
                issued = issued + 1;
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", o_rd_addr, addr_q.pop_front());
            end
            if (o_valid && i_ready) begin
                popped = popped + 1;
                beats  = beats + 1;
                if (first_rel < 0) first_rel = cyc - t0;
                last_rel = cyc - t0;
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat_data", o_data, exp_q.pop_front());
            end
            chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (o_done) done_rel = cyc - t0;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
        end
    end

    task automatic start_cmd(input int base, input int len);
        beats = 0; rd_cnt = 0; first_rel = -1; last_rel = -1; done_rel = -1;
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[(base + i) % 256]);
            addr_q.push_back(8'((base + i) % 256));
        end
        i_start = 1'b1; i_base = 8'(base); i_len = 9'(len); t0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0; i_base = 8'($urandom); i_len = 9'($urandom);
    endtask

    task automatic run_cmd(input int base, input int len, input bit timed, input bit extra_start);
        bit seen = 1'b0;
        start_cmd(base, len);
        if (extra_start) begin
            repeat (3) @(posedge clk);
            #1; i_start = 1'b1; i_base = 8'hA0; i_len = 9'd9;
            @(posedge clk); #1; i_start = 1'b0;
        end
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (o_done) begin seen = 1'b1; break; end
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #1;
        chk("beat_count", beats, len);
        chk("read_count", rd_cnt, len);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (timed) begin
            chk("done_cycle", done_rel, (len == 0) ? 1 : len + 2);
            if (len > 0) begin
                chk("first_beat_cycle", first_rel, 2);
                chk("last_beat_cycle", last_rel, len + 1);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'(a * 3);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_data", o_data, 0);
        chk("rst_addr", o_rd_addr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_cmd(8'h10, 4, 1, 0);
        run_cmd(8'hFE, 4, 1, 0);
        run_cmd(0, 0, 1, 0);
        run_cmd(8'h40, 16, 1, 1);
        run_cmd(0, 256, 1, 0);

        rnd_ready = 1'b1;
        run_cmd(8'h22, 8, 0, 0);
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        for (int n = 0; n < 6; n++) begin
            run_cmd($urandom_range(0, 255), $urandom_range(1, 40), 0, 0);
        end
        rnd_ready = 1'b0;

        start_cmd(8'h80, 10);
        for (int k = 0; k < 100 && beats < 3; k++) @(negedge clk);
        chk("beats_before_reset", beats >= 3, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_rd_en", o_rd_en, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_addr", o_rd_addr, 0);
        exp_q.delete();
        addr_q.delete();
        issued = 0; popped = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_idle_valid", o_valid, 0);
        end
        run_cmd(8'h05, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

`default_nettype wire
